// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-entry output FIFO.
// Illegal requests are consumed and raise a sticky error flag.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  op_i,
    input  logic        imm_sel_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [19:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic [15:0] emit_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    state_e      state_q, state_d;
    logic [31:0] slot0_q, slot0_d;
    logic [31:0] slot1_q, slot1_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        legal;
    logic [31:0] word;
    logic        in_fire;
    logic        push;
    logic        pop;

    // Handshake readiness comes from registered occupancy only.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign instr_o     = out_valid_o ? slot0_q : 32'h0;
    assign err_o       = err_q;
    assign emit_cnt_o  = cnt_q;

    assign in_fire = in_valid_i & in_ready_o;
    assign push    = in_fire & legal;
    assign pop     = out_valid_o & out_ready_i;

    // Encode the request and classify it as legal or illegal.
    always_comb begin
        legal = 1'b0;
        word  = 32'h0;
        case ({op_i, imm_sel_i})
            {4'd0, 1'b0}: begin
                legal = 1'b1;
                word  = {7'b0000000, rs2_i, rs1_i, 3'b000, rd_i, OPC_REG};
            end
            {4'd1, 1'b0}: begin
                legal = 1'b1;
                word  = {7'b0100000, rs2_i, rs1_i, 3'b000, rd_i, OPC_REG};
            end
            {4'd0, 1'b1}: begin
                legal = 1'b1;
                word  = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_IMM};
            end
            {4'd3, 1'b1}: begin
                legal = 1'b1;
                word  = {imm_i[11:0], rs1_i, 3'b110, rd_i, OPC_IMM};
            end
            {4'd4, 1'b1}: begin
                legal = (imm_i[11:5] == 7'd0);
                word  = {7'b0000000, imm_i[4:0], rs1_i, 3'b001, rd_i, OPC_IMM};
            end
            {4'd5, 1'b1}: begin
                legal = (imm_i[11:5] == 7'd0);
                word  = {7'b0000000, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_IMM};
            end
            {4'd2, 1'b1}: begin
                legal = 1'b1;
                word  = {imm_i, rd_i, OPC_LUI};
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0;
            end
        endcase
    end

    // Next-state for occupancy, slot contents, error flag and counter.
    // slot0 always holds the oldest word; slot1 the younger one.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        err_d   = err_q | (in_fire & ~legal);
        cnt_d   = cnt_q + {15'd0, pop};
        case (state_q)
            EMPTY: begin
                if (push) begin
                    slot0_d = word;
                    state_d = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        slot1_d = word;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: slot0_d = word;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous reset that drops all contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            slot0_q <= 32'h0;
            slot1_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
